// File: rtl/rv_pkg.sv
// Shared decode constants, field geometry and the decoded-field bundle.
// Imported by the decode stage and its register file.
package rv_pkg;

    localparam int XLEN_DEF = 32;

    localparam int OPC_W = 7;
    localparam int F3_W  = 3;
    localparam int F7_W  = 7;
    localparam int REG_W = 5;

    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

    localparam logic [OPC_W-1:0] OPC_RTYPE = 7'b0110011;
    localparam logic [F7_W-1:0]  F7_ADD    = 7'b0000000;
    localparam logic [F7_W-1:0]  F7_SUB    = 7'b0100000;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [F3_W-1:0]  func3;
        logic [F7_W-1:0]  func7;
        logic [REG_W-1:0] rd;
        logic             illegal;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t d;
        d.opcode  = instr[OPC_W-1:0];
        d.func3   = instr[F3_LSB +: F3_W];
        d.func7   = instr[F7_LSB +: F7_W];
        d.rd      = instr[RD_LSB +: REG_W];
        d.illegal = (d.opcode != OPC_RTYPE) ||
                    !((d.func7 == F7_ADD) || (d.func7 == F7_SUB));
        return d;
    endfunction

endpackage

// File: rtl/rv_regfile.sv
// Integer register file: two combinational read ports, one write port.
// Register 0 is hardwired to zero; reset clears every entry.
module rv_regfile
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic [AW-1:0]   ra1,
    output logic [XLEN-1:0] rd1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs [NREG];

    // Synchronous clear on reset; writes to index 0 are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    // Read ports see the stored value, never the write in flight.
    always_comb begin
        rd1 = (ra1 == '0) ? '0 : regs[ra1];
        rd2 = (ra2 == '0) ? '0 : regs[ra2];
    end

endmodule

// File: rtl/r_decode_stage.sv
// R-type decode stage: decodes fields, reads operands, holds one op for the ALU.
// Build option: RV_RF_BYPASS_EN forwards a same-cycle writeback into operands.
module r_decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_func3,
    output logic [6:0]      out_func7,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic            out_illegal
);

    localparam int AW = $clog2(NREG);

    logic            accept;
    logic            rf_we;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rf_a;
    logic [XLEN-1:0] rf_b;
    logic [XLEN-1:0] a_nxt;
    logic [XLEN-1:0] b_nxt;
    dec_t            dec;
    dec_t            held;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign rs1      = in_instr[RS1_LSB +: REG_W];
    assign rs2      = in_instr[RS2_LSB +: REG_W];
    assign rf_we    = wb_en && (wb_rd != '0);
    assign dec      = decode(in_instr);

    rv_regfile #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (AW)
    ) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (rf_we),
        .wa    (wb_rd[AW-1:0]),
        .wd    (wb_data),
        .ra1   (rs1[AW-1:0]),
        .rd1   (rf_a),
        .ra2   (rs2[AW-1:0]),
        .rd2   (rf_b)
    );

    // Operand select: optionally forward a writeback landing this cycle.
    always_comb begin
        a_nxt = rf_a;
        b_nxt = rf_b;
`ifdef RV_RF_BYPASS_EN
        if (rf_we && (wb_rd == rs1)) begin
            a_nxt = wb_data;
        end
        if (rf_we && (wb_rd == rs2)) begin
            b_nxt = wb_data;
        end
`else
        a_nxt = rf_a;
        b_nxt = rf_b;
`endif
    end

    // Output holding register: load on accept, drain on consume, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            held      <= '0;
            out_a     <= '0;
            out_b     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            held      <= dec;
            out_a     <= a_nxt;
            out_b     <= b_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_opcode  = held.opcode;
    assign out_func3   = held.func3;
    assign out_func7   = held.func7;
    assign out_rd      = held.rd;
    assign out_illegal = held.illegal;

endmodule

// File: tb/tb_r_decode_stage.sv
// Self-checking bench for r_decode_stage: scoreboard of expected ops.
// Build with +define+RV_RF_BYPASS_EN to check the forwarding variant.
module tb_r_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_opcode;
    logic [2:0]  out_func3;
    logic [6:0]  out_func7;
    logic [4:0]  out_rd;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic        out_illegal;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
    } exp_t;

    exp_t        sbq[$];
    exp_t        last;
    logic [31:0] mreg [32];
    int          checks;
    int          errors;

    r_decode_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_func3   (out_func3),
        .out_func7   (out_func7),
        .out_rd      (out_rd),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [6:0] f7,
                                        input logic [4:0] r2,
                                        input logic [4:0] r1,
                                        input logic [2:0] f3,
                                        input logic [4:0] rd,
                                        input logic [6:0] opc);
        return {f7, r2, r1, f3, rd, opc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_rd   = r;
        wb_data = d;
        step();
        wb_en   = 1'b0;
        if (r != 5'd0) mreg[r] = d;
    endtask

    // Build the expected op from the bench's own register model.
    task automatic push_exp(input logic [31:0] ins);
        exp_t        e;
        logic [4:0]  r1;
        logic [4:0]  r2;
        r1    = ins[19:15];
        r2    = ins[24:20];
        e.opc = ins[6:0];
        e.f3  = ins[14:12];
        e.f7  = ins[31:25];
        e.rd  = ins[11:7];
        e.a   = (r1 == 5'd0) ? 32'd0 : mreg[r1];
        e.b   = (r2 == 5'd0) ? 32'd0 : mreg[r2];
`ifdef RV_RF_BYPASS_EN
        if (wb_en && wb_rd != 5'd0 && wb_rd == r1) e.a = wb_data;
        if (wb_en && wb_rd != 5'd0 && wb_rd == r2) e.b = wb_data;
`endif
        e.ill = (e.opc != 7'b0110011) ||
                !((e.f7 == 7'b0000000) || (e.f7 == 7'b0100000));
        sbq.push_back(e);
    endtask

    task automatic cmp_out(input string nm, input exp_t e);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s valid: got %b want 1", nm, out_valid);
        end
        checks++;
        if ({out_opcode, out_func3, out_func7, out_rd} !==
            {e.opc, e.f3, e.f7, e.rd}) begin
            errors++;
            $display("FAIL %s fields: got %h/%h/%h/%h want %h/%h/%h/%h",
                     nm, out_opcode, out_func3, out_func7, out_rd,
                     e.opc, e.f3, e.f7, e.rd);
        end
        checks++;
        if (out_a !== e.a || out_b !== e.b) begin
            errors++;
            $display("FAIL %s operands: got a=%h b=%h want a=%h b=%h",
                     nm, out_a, out_b, e.a, e.b);
        end
        checks++;
        if (out_illegal !== e.ill) begin
            errors++;
            $display("FAIL %s illegal: got %b want %b", nm, out_illegal, e.ill);
        end
    endtask

    // Drive one instruction (in_valid left high), then pop and compare.
    task automatic issue(input string nm, input logic [31:0] ins);
        in_valid = 1'b1;
        in_instr = ins;
        push_exp(ins);
        step();
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", nm);
        end else begin
            last = sbq.pop_front();
            cmp_out(nm, last);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        wb_en     = 1'b0;
        wb_rd     = 5'd0;
        wb_data   = 32'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got v=%b ill=%b want 0/0",
                     out_valid, out_illegal);
        end
        checks++;
        if ({out_opcode, out_func3, out_func7, out_rd, out_a, out_b} !== '0) begin
            errors++;
            $display("FAIL reset_fields: got %h %h %h %h %h %h want all 0",
                     out_opcode, out_func3, out_func7, out_rd, out_a, out_b);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        wr(5'd5, 32'h0000_0010);
        wr(5'd6, 32'h0000_0003);
        issue("add", 32'h0062_83B3);
        in_valid = 1'b0;
    endtask

    task automatic test_stall();
        exp_t held;
        held      = last;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = enc(7'h00, 5'd5, 5'd6, 3'd0, 5'd9, 7'h33);
        for (int i = 0; i < 3; i++) begin
            wb_en   = 1'b1;
            wb_rd   = 5'd6;
            wb_data = 32'h0000_0100 + i;
            step();
            mreg[6] = 32'h0000_0100 + i;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_in_ready: got %b want 0", in_ready);
            end
            cmp_out("stall_hold", held);
        end
        wb_en     = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_in_ready: got %b want 1", in_ready);
        end
        issue("release", in_instr);
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        issue("b2b_0", enc(7'h20, 5'd6, 5'd5, 3'd0, 5'd10, 7'h33));
        issue("b2b_1", enc(7'h00, 5'd5, 5'd6, 3'd7, 5'd11, 7'h33));
        issue("b2b_2", enc(7'h00, 5'd0, 5'd6, 3'd4, 5'd31, 7'h33));
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_x0();
        wr(5'd0, 32'hDEAD_BEEF);
        issue("sub_x0", enc(7'h20, 5'd0, 5'd0, 3'd0, 5'd1, 7'h33));
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_bypass();
        wb_en   = 1'b1;
        wb_rd   = 5'd5;
        wb_data = 32'h0000_0055;
        issue("bypass", enc(7'h00, 5'd6, 5'd5, 3'd0, 5'd12, 7'h33));
        wb_en   = 1'b0;
        mreg[5] = 32'h0000_0055;
        issue("after_wr", enc(7'h00, 5'd5, 5'd5, 3'd0, 5'd13, 7'h33));
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_illegal_reset();
        issue("bad_f7", enc(7'h01, 5'd6, 5'd5, 3'd0, 5'd2, 7'h33));
        issue("addi", 32'h0000_0013);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        cmp_out("ill_stalled", last);
        rst_n   = 1'b0;
        wb_en   = 1'b1;
        wb_rd   = 5'd3;
        wb_data = 32'h0000_0077;
        step();
        wb_en = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        checks++;
        if (out_valid !== 1'b0 || out_illegal !== 1'b0 || out_a !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b ill=%b a=%h want 0/0/0",
                     out_valid, out_illegal, out_a);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_in_ready: got %b want 1", in_ready);
        end
        out_ready = 1'b1;
        for (int r = 0; r < 32; r += 2) begin
            issue("rf_cleared",
                  enc(7'h00, 5'(r + 1), 5'(r), 3'd0, 5'd1, 7'h33));
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_stall();
        test_back_to_back();
        test_x0();
        test_bypass();
        test_illegal_reset();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d want 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
